alu_sequencer: RTL

Parametrised successor to the board-level ALU/register datapath. It holds a bank of NREGS registers of WIDTH bits and runs one command per debounced press of the trigger button: two-operand ALU ops, load, swap, clear, and an optional multi-cycle shift-add multiply. It reports busy/done status and carry/zero/overflow flags. It sits between the switch/button inputs and the LED and seven-segment display logic, and replaces the fixed 8-bit A/B pair clocked directly by the button.

---
 rtl/alu_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Register-bank ALU sequencer: debounced trigger launches one command on the register bank.
// Define MUL_EN to build the multi-cycle shift-add multiplier (op 1000); otherwise op 1000 is a NOP.
module alu_sequencer #(
   parameter int WIDTH           = 8,
   parameter int NREGS           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   localparam int SELW           = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             trigger,
   input  logic [3:0]       op,
   input  logic [SELW-1:0]  dst,
   input  logic [SELW-1:0]  src,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] y_out,
   output logic             busy,
   output logic             done,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_CMP  = 4'b1001;
   localparam logic [3:0] OP_LOAD = 4'b1101;
   localparam logic [3:0] OP_SWAP = 4'b1110;
   localparam logic [3:0] OP_CLR  = 4'b1111;
   localparam int CNTW = $clog2(DEBOUNCE_CYCLES);

`ifdef MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam int MCW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
`else
   typedef enum logic {S_IDLE, S_EXEC} state_t;
`endif

   state_t r_state, w_nextState;

   logic             r_sync1, r_sync2, r_level, r_levelDly;
   logic [CNTW-1:0]  r_dbCnt;
   logic             w_strobe, w_accept, w_finish;

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [3:0]       r_op;
   logic [SELW-1:0]  r_dst, r_src;
   logic [WIDTH-1:0] r_lit, r_y;
   logic             r_done, r_carry, r_zero, r_ovf;

   logic [WIDTH-1:0] w_d, w_s, w_result;
   logic [WIDTH:0]   w_sum, w_diff;
   logic             w_carry, w_wrDst, w_wrSrc, w_updFlags;

`ifdef MUL_EN
   logic [2*WIDTH-1:0] r_mulAcc, r_mulCand, w_mulNext;
   logic [WIDTH-1:0]   r_mulPlier;
   logic [MCW-1:0]     r_mulCnt;
   logic               w_mulLast;
`endif

   // A new level is accepted only after an unbroken run of samples that differ from the current one.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_level    <= 1'b0;
         r_levelDly <= 1'b0;
         r_dbCnt    <= '0;
      end else begin
         r_sync1    <= trigger;
         r_sync2    <= r_sync1;
         r_levelDly <= r_level;
         if (r_sync2 == r_level) begin
            r_dbCnt <= '0;
         end else if (r_dbCnt == CNTW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_dbCnt <= '0;
         end else begin
            r_dbCnt <= r_dbCnt + 1'b1;
         end
      end
   end

   assign w_strobe = r_level & ~r_levelDly;

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_strobe) begin
               w_nextState = S_EXEC;
`ifdef MUL_EN
               if (op == OP_MUL) w_nextState = S_MUL;
`endif
            end
         end
         S_EXEC: w_nextState = S_IDLE;
`ifdef MUL_EN
         S_MUL:  if (w_mulLast) w_nextState = S_IDLE;
`endif
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != S_IDLE);
      w_accept = (r_state == S_IDLE) && w_strobe;
`ifdef MUL_EN
      w_finish = (r_state == S_EXEC) || ((r_state == S_MUL) && w_mulLast);
`else
      w_finish = (r_state == S_EXEC);
`endif
   end

   // Single-cycle result; anything not listed (including the reserved codes) leaves all state alone.
   always_comb begin
      w_d        = r_regs[r_dst];
      w_s        = r_regs[r_src];
      w_sum      = {1'b0, w_d} + {1'b0, w_s};
      w_diff     = {1'b0, w_d} - {1'b0, w_s};
      w_result   = '0;
      w_carry    = r_carry;
      w_wrDst    = 1'b0;
      w_wrSrc    = 1'b0;
      w_updFlags = 1'b1;
      case (r_op)
         OP_ADD:  begin w_result = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  w_wrDst = 1'b1; end
         OP_SUB:  begin w_result = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; w_wrDst = 1'b1; end
         OP_AND:  begin w_result = w_d & w_s; w_wrDst = 1'b1; end
         OP_OR:   begin w_result = w_d | w_s; w_wrDst = 1'b1; end
         OP_XOR:  begin w_result = w_d ^ w_s; w_wrDst = 1'b1; end
         OP_NOT:  begin w_result = ~w_d;      w_wrDst = 1'b1; end
         OP_SHL:  begin w_result = {w_d[WIDTH-2:0], 1'b0}; w_carry = w_d[WIDTH-1]; w_wrDst = 1'b1; end
         OP_SHR:  begin w_result = {1'b0, w_d[WIDTH-1:1]}; w_carry = w_d[0];       w_wrDst = 1'b1; end
         OP_CMP:  begin w_result = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
         OP_LOAD: begin w_result = r_lit; w_wrDst = 1'b1; end
         OP_SWAP: begin w_result = w_s; w_wrDst = 1'b1; w_wrSrc = 1'b1; end
         OP_CLR:  begin w_result = '0;  w_wrDst = 1'b1; end
         default: w_updFlags = 1'b0;
      endcase
   end

`ifdef MUL_EN
   assign w_mulNext = r_mulAcc + (r_mulPlier[0] ? r_mulCand : '0);
   assign w_mulLast = (r_mulCnt == MCW'(WIDTH - 1));
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_op    <= '0;
         r_dst   <= '0;
         r_src   <= '0;
         r_lit   <= '0;
         r_y     <= '0;
         r_done  <= 1'b0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef MUL_EN
         r_mulAcc   <= '0;
         r_mulCand  <= '0;
         r_mulPlier <= '0;
         r_mulCnt   <= '0;
`endif
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_op  <= op;
            r_dst <= dst;
            r_src <= src;
            r_lit <= data_in;
`ifdef MUL_EN
            r_mulAcc   <= '0;
            r_mulCand  <= {{WIDTH{1'b0}}, r_regs[dst]};
            r_mulPlier <= r_regs[src];
            r_mulCnt   <= '0;
`endif
         end
         if (r_state == S_EXEC) begin
            if (w_wrDst) r_regs[r_dst] <= w_result;
            if (w_wrSrc) r_regs[r_src] <= w_d;
            if (w_updFlags) begin
               r_y     <= w_result;
               r_zero  <= (w_result == '0);
               r_carry <= w_carry;
            end
         end
`ifdef MUL_EN
         if (r_state == S_MUL) begin
            r_mulAcc   <= w_mulNext;
            r_mulCand  <= r_mulCand << 1;
            r_mulPlier <= r_mulPlier >> 1;
            r_mulCnt   <= r_mulCnt + 1'b1;
            if (w_mulLast) begin
               r_regs[r_dst] <= w_mulNext[WIDTH-1:0];
               r_y           <= w_mulNext[WIDTH-1:0];
               r_zero        <= (w_mulNext[WIDTH-1:0] == '0);
               r_ovf         <= |w_mulNext[2*WIDTH-1:WIDTH];
            end
         end
`endif
      end
   end

   assign a_out = r_regs[dst];
   assign b_out = r_regs[src];
   assign y_out = r_y;
   assign done  = r_done;
   assign carry = r_carry;
   assign zero  = r_zero;
   assign ovf   = r_ovf;

endmodule
